// File: rtl/jt51_noise_gen_pkg.sv
// Shared definitions for the jt51 noise generator: default taps/seed,
// lock-up state helper and a table of maximal-length tap masks.
package jt51_noise_gen_pkg;

    localparam int unsigned DefW    = 17;
    localparam logic [16:0] DefTaps = 17'h12000;
    localparam logic [16:0] DefInit = 17'd14220;

    // XNOR feedback locks up at all ones, XOR feedback at all zeros.
    function automatic logic [63:0] lockup_word(int unsigned w, bit xnor_fb);
        return xnor_fb ? ((64'd1 << w) - 64'd1) : 64'd0;
    endfunction

    // Maximal-length tap masks (bit n-1 for tap n), valid for w = 5..17.
    function automatic logic [31:0] prim_taps(int unsigned w);
        case (w)
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_D008;
            17:      return 32'h0001_2000;
            default: return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/jt51_noise_gen_if.sv
// Control and observation bundle for the noise generator.
interface jt51_noise_gen_if #(
    parameter int unsigned W    = 17,
    parameter int unsigned DIVW = 5
);
    logic            clk_en;
    logic            ne;
    logic [DIVW-1:0] nfrq;
    logic            seed_we;
    logic [W-1:0]    seed;
    logic            out;
    logic [W-1:0]    lfsr;
    logic            tick;
    logic            lock_fix;

    modport master (
        output clk_en, ne, nfrq, seed_we, seed,
        input  out, lfsr, tick, lock_fix
    );

    modport slave (
        input  clk_en, ne, nfrq, seed_we, seed,
        output out, lfsr, tick, lock_fix
    );
endinterface

// File: rtl/jt51_noise_gen_div.sv
// Programmable rate divider: raises step once every (2^DIVW - nfrq) clk_en cycles.
module jt51_noise_gen_div #(
    parameter int unsigned DIVW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clk_en,
    input  logic            ne,
    input  logic [DIVW-1:0] nfrq,
    input  logic            clr,
    output logic            step
);
    logic [DIVW-1:0] cnt_q;
    logic [DIVW-1:0] term;

    // Terminal count; >= lets a lowered terminal fire at once instead of wrapping.
    always_comb begin
        term = ~nfrq;
        step = clk_en & ne & (cnt_q >= term);
    end

    // Counter: cleared by reset or seed write, advances on qualified cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (clk_en && ne) begin
            cnt_q <= step ? '0 : cnt_q + DIVW'(1);
        end
    end
endmodule

// File: rtl/jt51_noise_gen.sv
// Parametrised noise LFSR with rate divider, seed loading and lock-up recovery.
module jt51_noise_gen
    import jt51_noise_gen_pkg::*;
#(
    parameter int unsigned  W    = DefW,
    parameter logic [W-1:0] TAPS = W'(DefTaps),
    parameter bit           XNOR = 1'b1,
    parameter logic [W-1:0] INIT = W'(DefInit),
    parameter int unsigned  DIVW = 5
) (
    input  logic               clk,
    input  logic               rst,
    jt51_noise_gen_if.slave    bus
);
    localparam logic [W-1:0] LockVal = W'(lockup_word(W, XNOR));

    if ((W < 3) || (INIT == LockVal)) begin : g_param_err
        $error("jt51_noise_gen: W must be >= 3 and INIT must differ from the lock-up state");
    end

    logic [W-1:0] lfsr_q;
    logic         tick_q;
    logic         lock_fix_q;
    logic         step;
    logic         fb;

    jt51_noise_gen_div #(
        .DIVW (DIVW)
    ) u_div (
        .clk    (clk),
        .rst    (rst),
        .clk_en (bus.clk_en),
        .ne     (bus.ne),
        .nfrq   (bus.nfrq),
        .clr    (bus.seed_we),
        .step   (step)
    );

    // Feedback bit from the tapped positions.
    always_comb begin
        fb = (^(lfsr_q & TAPS)) ^ XNOR;
    end

    // LFSR state: seed write beats step; lock-up state is replaced by INIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q     <= INIT;
            tick_q     <= 1'b0;
            lock_fix_q <= 1'b0;
        end else begin
            tick_q     <= 1'b0;
            lock_fix_q <= 1'b0;
            if (bus.seed_we) begin
                if (bus.seed == LockVal) begin
                    lfsr_q     <= INIT;
                    lock_fix_q <= 1'b1;
                end else begin
                    lfsr_q <= bus.seed;
                end
            end else if (step) begin
                tick_q <= 1'b1;
                if (lfsr_q == LockVal) begin
                    lfsr_q     <= INIT;
                    lock_fix_q <= 1'b1;
                end else begin
                    lfsr_q <= {lfsr_q[W-2:0], fb};
                end
            end
        end
    end

    assign bus.lfsr     = lfsr_q;
    assign bus.out      = lfsr_q[W-1];
    assign bus.tick     = tick_q;
    assign bus.lock_fix = lock_fix_q;
endmodule

// File: tb/tb_jt51_noise_gen.sv
// Directed bench for jt51_noise_gen: default 17-bit instance plus a 5-bit instance.
module tb_jt51_noise_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    jt51_noise_gen_if #(.W(17), .DIVW(5)) bus ();
    jt51_noise_gen_if #(.W(5),  .DIVW(5)) bus5 ();

    jt51_noise_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    jt51_noise_gen #(
        .W    (5),
        .TAPS (5'b10100),
        .XNOR (1'b1),
        .INIT (5'd1),
        .DIVW (5)
    ) dut5 (
        .clk (clk),
        .rst (rst),
        .bus (bus5.slave)
    );

    // Advance one clock and settle just past the edge.
    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step_clk();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.clk_en = 1'b0; bus.ne = 1'b0; bus.nfrq = 5'd0; bus.seed_we = 1'b0; bus.seed = '0;
        bus5.clk_en = 1'b0; bus5.ne = 1'b0; bus5.nfrq = 5'd0; bus5.seed_we = 1'b0; bus5.seed = '0;
        rst = 1'b1;
        step_clk();
        step_clk();
        rst = 1'b0;
        tests++; if (bus.lfsr !== 17'd14220) begin failed++;
            $display("FAIL reset_lfsr: got %0d want 14220", bus.lfsr); end
        tests++; if (bus.out !== 1'b0) begin failed++;
            $display("FAIL reset_out: got %b want 0", bus.out); end
        tests++; if (bus.tick !== 1'b0) begin failed++;
            $display("FAIL reset_tick: got %b want 0", bus.tick); end
        tests++; if (bus.lock_fix !== 1'b0) begin failed++;
            $display("FAIL reset_lock_fix: got %b want 0", bus.lock_fix); end
    endtask

    task automatic test_fast_shift();
        logic [16:0] exp_seq [3];
        exp_seq[0] = 17'd28440; exp_seq[1] = 17'd56880; exp_seq[2] = 17'h1BC61;
        do_reset();
        bus.ne = 1'b1; bus.nfrq = 5'd31; bus.clk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step_clk();
            tests++; if (bus.lfsr !== exp_seq[i] || bus.tick !== 1'b1) begin failed++;
                $display("FAIL fast_shift[%0d]: got lfsr=%h tick=%b want lfsr=%h tick=1",
                         i, bus.lfsr, bus.tick, exp_seq[i]); end
        end
        tests++; if (bus.out !== 1'b1) begin failed++;
            $display("FAIL fast_out: got %b want 1", bus.out); end
        bus.ne = 1'b0;
        step_clk();
        tests++; if (bus.lfsr !== 17'h1BC61 || bus.tick !== 1'b0) begin failed++;
            $display("FAIL ne_stop: got lfsr=%h tick=%b want 1bc61/0", bus.lfsr, bus.tick); end
    endtask

    // Gap in clk cycles between two consecutive ticks.
    task automatic test_period(input logic [4:0] nfrq, input bit toggle, input int exp_gap);
        int  gap;
        bit  seen;
        do_reset();
        bus.ne = 1'b1; bus.nfrq = nfrq; bus.clk_en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            step_clk();
            seen = bus.tick;
            if (toggle) bus.clk_en = ~bus.clk_en;
        end
        gap = 0;
        if (seen) begin
            seen = 1'b0;
            for (int i = 0; i < 100 && !seen; i++) begin
                step_clk();
                gap++;
                seen = bus.tick;
                if (toggle) bus.clk_en = ~bus.clk_en;
            end
        end
        bus.clk_en = 1'b1;
        tests++; if (!seen || gap != exp_gap) begin failed++;
            $display("FAIL period_nfrq%0d_tog%0d: got gap %0d want %0d", nfrq, toggle, gap,
                     exp_gap); end
    endtask

    task automatic test_term_lower();
        int ticks;
        do_reset();
        bus.ne = 1'b1; bus.nfrq = 5'd0; bus.clk_en = 1'b1;
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            step_clk();
            if (bus.tick) ticks++;
        end
        tests++; if (ticks != 0) begin failed++;
            $display("FAIL term_lower_quiet: got %0d ticks want 0", ticks); end
        bus.nfrq = 5'd20;
        step_clk();
        tests++; if (bus.tick !== 1'b1 || bus.lfsr !== 17'd28440) begin failed++;
            $display("FAIL term_lower_fire: got tick=%b lfsr=%0d want 1/28440", bus.tick,
                     bus.lfsr); end
    endtask

    task automatic test_seed();
        do_reset();
        bus.ne = 1'b0; bus.clk_en = 1'b0;
        bus.seed = 17'h1FFFF; bus.seed_we = 1'b1;
        step_clk();
        bus.seed_we = 1'b0;
        tests++; if (bus.lfsr !== 17'd14220 || bus.lock_fix !== 1'b1 || bus.tick !== 1'b0) begin
            failed++;
            $display("FAIL seed_lockup: got lfsr=%0d lock_fix=%b tick=%b want 14220/1/0",
                     bus.lfsr, bus.lock_fix, bus.tick); end
        step_clk();
        tests++; if (bus.lock_fix !== 1'b0) begin failed++;
            $display("FAIL seed_lockup_pulse: got lock_fix=%b want 0", bus.lock_fix); end
        // Period 3: step due on the third clk_en after reset.
        do_reset();
        bus.ne = 1'b1; bus.nfrq = 5'd29; bus.clk_en = 1'b1;
        step_clk();
        step_clk();
        bus.seed = 17'h00001; bus.seed_we = 1'b1;
        step_clk();
        bus.seed_we = 1'b0;
        tests++; if (bus.lfsr !== 17'd1 || bus.tick !== 1'b0 || bus.lock_fix !== 1'b0) begin
            failed++;
            $display("FAIL seed_on_step: got lfsr=%h tick=%b lock_fix=%b want 1/0/0",
                     bus.lfsr, bus.tick, bus.lock_fix); end
        step_clk();
        step_clk();
        tests++; if (bus.tick !== 1'b0 || bus.lfsr !== 17'd1) begin failed++;
            $display("FAIL seed_wait: got tick=%b lfsr=%h want 0/1", bus.tick, bus.lfsr); end
        step_clk();
        tests++; if (bus.tick !== 1'b1 || bus.lfsr !== 17'd3) begin failed++;
            $display("FAIL seed_next_step: got tick=%b lfsr=%h want 1/3", bus.tick, bus.lfsr); end
    endtask

    task automatic test_w5();
        logic [4:0] seen_st [31];
        bit         ones_seen;
        bit         dup;
        do_reset();
        bus.ne = 1'b0;
        bus5.ne = 1'b1; bus5.nfrq = 5'd31; bus5.clk_en = 1'b1;
        ones_seen = 1'b0;
        for (int i = 0; i < 31; i++) begin
            step_clk();
            seen_st[i] = bus5.lfsr;
            if (bus5.lfsr == 5'h1F) ones_seen = 1'b1;
        end
        bus5.ne = 1'b0;
        tests++; if (seen_st[0] !== 5'd3) begin failed++;
            $display("FAIL w5_first: got %h want 03", seen_st[0]); end
        tests++; if (ones_seen) begin failed++;
            $display("FAIL w5_all_ones: got all-ones state want never"); end
        dup = 1'b0;
        for (int i = 0; i < 31; i++)
            for (int j = i + 1; j < 31; j++)
                if (seen_st[i] == seen_st[j]) dup = 1'b1;
        tests++; if (dup) begin failed++;
            $display("FAIL w5_distinct: got repeated state want 31 distinct"); end
        tests++; if (seen_st[30] !== 5'd1) begin failed++;
            $display("FAIL w5_period: got %h after 31 steps want 01", seen_st[30]); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.ne = 1'b1; bus.nfrq = 5'd0; bus.clk_en = 1'b1;
        for (int i = 0; i < 10; i++) step_clk();
        bus.nfrq = 5'd29;
        bus.clk_en = 1'b0;
        rst = 1'b1;
        step_clk();
        rst = 1'b0;
        bus.clk_en = 1'b1;
        tests++; if (bus.lfsr !== 17'd14220 || bus.tick !== 1'b0) begin failed++;
            $display("FAIL reset_mid: got lfsr=%0d tick=%b want 14220/0", bus.lfsr, bus.tick); end
        step_clk();
        step_clk();
        tests++; if (bus.tick !== 1'b0) begin failed++;
            $display("FAIL reset_mid_cnt_early: got tick=%b want 0", bus.tick); end
        step_clk();
        tests++; if (bus.tick !== 1'b1 || bus.lfsr !== 17'd28440) begin failed++;
            $display("FAIL reset_mid_cnt: got tick=%b lfsr=%0d want 1/28440", bus.tick,
                     bus.lfsr); end
    endtask

    task automatic test_ne_hold();
        int ticks;
        do_reset();
        bus.ne = 1'b1; bus.nfrq = 5'd31; bus.clk_en = 1'b1;
        step_clk();
        step_clk();
        bus.ne = 1'b0;
        ticks = 0;
        for (int i = 0; i < 100; i++) begin
            step_clk();
            if (bus.tick) ticks++;
        end
        tests++; if (ticks != 0 || bus.lfsr !== 17'd56880) begin failed++;
            $display("FAIL ne_hold: got ticks=%0d lfsr=%0d want 0/56880", ticks, bus.lfsr); end
        bus.ne = 1'b1;
        step_clk();
        tests++; if (bus.tick !== 1'b1 || bus.lfsr !== 17'h1BC61) begin failed++;
            $display("FAIL ne_resume: got tick=%b lfsr=%h want 1/1bc61", bus.tick, bus.lfsr); end
    endtask

    initial begin
        test_reset();
        test_fast_shift();
        test_period(5'd0, 1'b0, 32);
        test_period(5'd29, 1'b0, 3);
        test_period(5'd31, 1'b1, 2);
        test_term_lower();
        test_seed();
        test_w5();
        test_reset_mid();
        test_ne_hold();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/jt51_noise_gen.md
Name: jt51_noise_gen

Overview:
Parametrised noise generator, successor to the fixed 17-bit noise LFSR. It generalises register width, tap set and feedback polarity, and adds:
- an internal programmable rate divider driven by the 5-bit noise-frequency register field;
- run-time seed loading;
- automatic lock-up recovery.
It sits in the operator/noise path and feeds channel 8 noise selection, with the LFSR word available for test and other noise consumers.

Parameters:
W, 17, LFSR width in bits (min 3).
TAPS, 17'h12000, W-bit feedback tap mask (default taps bits 16 and 13).
XNOR, 1, 1 = XNOR feedback (lock-up state all ones); 0 = XOR feedback (lock-up state all zeros).
INIT, 14220, reset/recovery seed, W bits; must not equal the lock-up state (elaboration check).
DIVW, 5, divider/frequency field width.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
clk_en  in  1  clock enable; divider and shift advance only on cycles with clk_en=1
ne  in  1  noise enable; 0 freezes the divider and LFSR
nfrq  in  DIVW  noise frequency; higher value gives faster shifting
seed_we  in  1  seed write strobe, acts on any clk cycle regardless of clk_en
seed  in  W  seed value
out  out  1  noise bit = lfsr[W-1]
lfsr  out  W  current LFSR state
tick  out  1  one-clk pulse marking a committed shift
lock_fix  out  1  one-clk pulse marking a lock-up substitution

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: lfsr=INIT, divider cnt=0, tick=0, lock_fix=0, so out=INIT[W-1].
- Divider:
  - Terminal value term = (2^DIVW-1) - nfrq.
  - On a clk_en cycle with ne=1: if cnt >= term, raise step and set cnt=0; else cnt+1.
  - The >= comparison means a lowering of term mid-count fires on the next clk_en; no wrap through 2^DIVW.
  - Period: (2^DIVW - nfrq) clk_en cycles. nfrq=31 steps every clk_en; nfrq=0 every 32.
- Shift on step:
  - fb = reduction-XOR of (lfsr & TAPS), inverted when XNOR=1.
  - lfsr <= {lfsr[W-2:0], fb}. tick=1 on the following clk cycle only.
- Lock-up recovery:
  - If a step is due while lfsr equals the lock-up state, load INIT instead of shifting; tick=1, lock_fix=1.
  - The lock-up state is reachable only via seed, and seed is filtered, so this is a guard only.
- Seed write (seed_we=1):
  - lfsr <= seed, or INIT with lock_fix=1 if seed equals the lock-up state.
  - cnt <= 0. Any step due in the same cycle is discarded; tick=0.
- ne=0: cnt held, lfsr held, tick=0. Seed writes still apply.
- clk_en=0: nothing advances except seed writes.
- Priority, highest first: rst > seed_we > step.
- Reset mid-count: asserting rst on any cycle restores the reset values on the next edge, independent of clk_en.
- Outputs are registered. Latency from the qualifying clk_en edge to new lfsr/out/tick is 1 clk.

Decomposition:
- Shared include jt51_noise_defs: lock-up value function (W, XNOR), default TAPS/INIT localparams, primitive tap masks for W=5..17.
- One sub-module, jt51_noise_div: DIVW counter, nfrq compare, ne/clk_en qualification, seed-clear input, step output.
- The LFSR/feedback/seed logic stays in the top module.

Test Plan:
- Reset with defaults -> lfsr=14220, out=0, tick=0. Then ne=1, nfrq=31, clk_en=1 constantly -> lfsr=28440, then 56880, one tick per clk.
- nfrq=0 -> ticks exactly 32 clk_en apart. nfrq=29 -> 3 apart. clk_en toggled 1/0 with nfrq=31 -> tick every 2 clk.
- nfrq=0, cnt=20, then nfrq changed to 20 (term=11) -> step on the next clk_en. No 32-cycle wait.
- seed_we with seed=17'h1FFFF -> lfsr=14220, lock_fix pulse. Then seed_we with 17'h00001 on a step cycle -> lfsr=1, tick=0, next step after a full period.
- W=5, TAPS=5'b10100, XNOR=1, INIT=1, nfrq=31 -> state sequence repeats with period 31, all-ones never appears.
- rst asserted mid-count with ne=1 -> next edge: lfsr=INIT, cnt=0, tick=0. ne=0 for 100 clk -> lfsr unchanged, no tick.
